// File: rtl/madd_cmd_pkg.sv
// Shared types for the DMADD command loader: command encoding, packed
// command word and loader FSM states.
package madd_cmd_pkg;

  // Number of DMADD registers swept by a CLEAR command.
  localparam int unsigned NUM_REGS = 16;

  typedef enum logic [1:0] {
    CmdLoad  = 2'b00,
    CmdRun   = 2'b01,
    CmdWait  = 2'b10,
    CmdClear = 2'b11
  } cmd_kind_t;

  typedef struct packed {
    cmd_kind_t  kind;
    logic [3:0] index;
    logic [3:0] data;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StWait,
    StClear
  } ld_state_t;

endpackage

// File: rtl/madd_cmd_fifo.sv
// Synchronous FIFO with registered occupancy count. Head entry is presented
// combinationally on rdata; push/pop are ignored when full/empty.
module madd_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/madd_cmd_loader.sv
// Command sequencer in front of the DMADD core. Buffers packed commands in a
// FIFO and replays them as registered load/run/insn/index/data strobes.
// Optional: define MADD_CMD_LOADER_BYPASS_EN to let a LOAD that arrives while
// the loader is completely idle skip the FIFO and strobe one cycle earlier.
module madd_cmd_loader
  import madd_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RUN_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_kind,
  input  logic [7:0]                  cmd_data,
  output logic                        madd_load,
  output logic                        madd_run,
  output logic [1:0]                  madd_insn,
  output logic [3:0]                  madd_index,
  output logic [3:0]                  madd_data,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam logic [3:0] RUN_LAST = 4'(RUN_CYCLES - 1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  ld_state_t        state_q;
  logic [3:0]       cnt_q;
  logic [CMD_W-1:0] fifo_rdata;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             bypass;
  logic             fifo_push;
  logic             fifo_pop;

  assign head      = fifo_rdata;
  assign cmd_ready = !fifo_full;
  assign accept    = cmd_valid && cmd_ready;

`ifdef MADD_CMD_LOADER_BYPASS_EN
  assign bypass = accept && (cmd_kind == CmdLoad) && fifo_empty && (state_q == StIdle);
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = accept && !bypass;
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;
  assign busy      = (state_q != StIdle) || !fifo_empty;

  madd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({cmd_kind, cmd_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_level)
  );

  // Loader FSM; strobes are set on the pop edge so they appear with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      madd_load  <= 1'b0;
      madd_run   <= 1'b0;
      madd_insn  <= '0;
      madd_index <= '0;
      madd_data  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bypass) begin
            madd_load  <= 1'b1;
            madd_index <= cmd_data[7:4];
            madd_data  <= cmd_data[3:0];
            state_q    <= StLoad;
          end else if (!fifo_empty) begin
            unique case (head.kind)
              CmdLoad: begin
                madd_load  <= 1'b1;
                madd_index <= head.index;
                madd_data  <= head.data;
                state_q    <= StLoad;
              end
              CmdRun: begin
                madd_run  <= 1'b1;
                madd_insn <= head.data[1:0];
                cnt_q     <= RUN_LAST;
                state_q   <= StRun;
              end
              CmdWait: begin
                // A zero-length wait costs only the pop cycle itself.
                if (head.data != 4'd0) begin
                  cnt_q   <= head.data - 4'd1;
                  state_q <= StWait;
                end
              end
              CmdClear: begin
                madd_load  <= 1'b1;
                madd_index <= 4'd0;
                madd_data  <= 4'd0;
                state_q    <= StClear;
              end
              default: state_q <= StIdle;
            endcase
          end
        end
        StLoad: begin
          madd_load <= 1'b0;
          state_q   <= StIdle;
        end
        StRun: begin
          if (cnt_q == 4'd0) begin
            madd_run <= 1'b0;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StClear: begin
          // Index saturates at the last register; no wrap back to 0.
          if (madd_index == LAST_IDX) begin
            madd_load <= 1'b0;
            state_q   <= StIdle;
          end else begin
            madd_index <= madd_index + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/madd_cmd_loader.md
Name: madd_cmd_loader

Overview:
- Upstream command sequencer for the DMADD multiply-add core. It sits between the chip pins and the core.
- Accepts packed 10-bit commands over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command as cycle-exact load/run/insn/index/data strobes toward DMADD.
- Decouples the slow pin-side host from core timing and adds WAIT and CLEAR macro-commands.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- RUN_CYCLES, 1, cycles madd_run is held high per RUN command; 1..15.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  host presents a command.
- cmd_ready  out  1  loader accepts the command this cycle; equals !fifo_full.
- cmd_kind  in  2  00 LOAD, 01 RUN, 10 WAIT, 11 CLEAR.
- cmd_data  in  8  {index[3:0], data[3:0]}.
- madd_load  out  1  to DMADD load.
- madd_run  out  1  to DMADD run.
- madd_insn  out  2  to DMADD insn.
- madd_index  out  4  to DMADD index.
- madd_data  out  4  to DMADD data.
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - FIFO pointers and count go to 0; FSM goes to IDLE.
  - All madd_* outputs go to 0; busy=0; fifo_level=0; cmd_ready=1 from the next cycle.
  - Reset mid-command aborts the command immediately: no further strobes, and partially issued CLEAR/RUN sequences are discarded.
- Handshake:
  - A transfer occurs when cmd_valid && cmd_ready at an edge.
  - {cmd_kind, cmd_data} is written to the FIFO at that edge.
  - cmd_ready depends only on registered count, never on cmd_valid. When full, ready=0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
- All madd_* outputs are registered; there are no combinational paths from cmd_* to madd_*.
- FSM states: IDLE, LOAD, RUN, WAIT, CLEAR.
  - IDLE: if the FIFO is non-empty, pop the head and branch on kind. If empty, stay in IDLE with all strobes 0.
  - LOAD: madd_load=1 for exactly 1 cycle, with madd_index/madd_data taken from the command. Next state is IDLE.
  - RUN: madd_run=1 for RUN_CYCLES consecutive cycles, with madd_insn=cmd_data[1:0] held stable throughout. index/data hold their previous values. Next state is IDLE.
  - WAIT: all strobes 0 for n=cmd_data[3:0] cycles. n=0 returns to IDLE the next cycle, giving a 1-cycle bubble only.
  - CLEAR: 16 consecutive madd_load=1 cycles with madd_index=0,1,..,15 and madd_data=0. The index counter stops at 15, does not wrap, and the FSM then goes to IDLE.
- Latency (no bypass): a command accepted at edge N is popped at edge N+1, and its first strobe is visible in cycle N+2.
- Back-to-back: the FSM returns through IDLE, so consecutive LOADs produce load pulses at most every 2 cycles.
- madd_load and madd_run are never both 1 in the same cycle.
- Outside LOAD/CLEAR cycles madd_index/madd_data hold their last value. madd_insn holds its last value outside RUN.

Optional Feature:
- Macro: MADD_CMD_LOADER_BYPASS_EN.
- Defined: a LOAD accepted while the FIFO is empty and the FSM is IDLE skips the FIFO. The output registers are loaded at the accept edge N, so madd_load=1 in cycle N+1. fifo_level stays 0 and busy=1 for that cycle. Non-LOAD kinds always go through the FIFO.
- Undefined: no bypass; latency is as specified above.

Decomposition:
- Package madd_cmd_pkg:
  - cmd_kind_t enum (LOAD/RUN/WAIT/CLEAR).
  - Packed cmd_t {kind, index, data}.
  - Loader FSM state enum.
  - NUM_REGS=16 constant.
- One sub-module: madd_cmd_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterised by depth and width.

Test Plan:
- LOAD idx=5 data=0xA, accepted at cycle 0 -> madd_load=1, index=5, data=0xA in cycle 2 only. With BYPASS_EN the same strobe appears in cycle 1.
- RUN insn=2 with RUN_CYCLES=3 -> madd_run=1 and insn=2 for exactly 3 consecutive cycles; load=0 throughout.
- CLEAR -> 16 consecutive load pulses, index 0..15, data=0; then busy=0 when the FIFO is empty.
- Push 5 commands back-to-back with FIFO_DEPTH=4 while the FSM is held in WAIT n=15 -> cmd_ready=0 after 4 accepts, fifo_level=4; the 5th is accepted once the first pop occurs. Commands execute in order.
- WAIT n=0 between two LOADs -> load pulses separated by exactly one extra idle cycle versus no WAIT.
- rst asserted on the 8th CLEAR cycle -> next cycle all madd_*=0, busy=0, fifo_level=0; the queued RUN behind the CLEAR never issues.
